// File: rtl/prog_imm_lut.sv
// ============================================================================
// Module   : prog_imm_lut
// Purpose  : Run-time programmable signed-immediate lookup table with
//            registered, sign-extended read port and self-clearing sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_imm_lut #(
    parameter int                ADDR_W    = 6,
    parameter int                DEPTH     = 20,
    parameter int                DATA_W    = 9,
    parameter int                OUT_W     = 16,
    parameter logic [DATA_W-1:0] OOR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic              ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [OUT_W-1:0]  rd_data,
    output logic              rd_oor
);

    localparam int                 c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]    c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t             r_state_q,    w_state_d;
    logic [c_IDX_W-1:0] r_cnt_q,      w_cnt_d;
    logic               r_ready_q,    w_ready_d;
    logic               r_rd_valid_q, w_rd_valid_d;
    logic [OUT_W-1:0]   r_rd_data_q,  w_rd_data_d;
    logic               r_rd_oor_q,   w_rd_oor_d;

    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_wr_in_range;
    logic               w_rd_in_range;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_wr_accept;
    logic               w_rd_accept;
    logic [DATA_W-1:0]  w_rd_entry;

    always_comb begin
        w_wr_in_range = ({1'b0, wr_addr} < c_DEPTH_EXT);
        w_rd_in_range = ({1'b0, rd_addr} < c_DEPTH_EXT);
        w_wr_idx      = wr_addr[c_IDX_W-1:0];
        w_rd_idx      = rd_addr[c_IDX_W-1:0];
        // A clear in the same cycle wins over the write but not over the read.
        w_wr_accept   = r_ready_q & wr_en & ~clear & w_wr_in_range;
        w_rd_accept   = r_ready_q & rd_en;
    end

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_ready_d = r_ready_q;
        case (r_state_q)
            ST_CLEAR: begin
                if (clear) begin
                    w_cnt_d = '0;
                end else if (r_cnt_q == c_LAST_IDX) begin
                    w_state_d = ST_READY;
                    w_ready_d = 1'b1;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (clear) begin
                    w_state_d = ST_CLEAR;
                    w_ready_d = 1'b0;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = ST_CLEAR;
                w_ready_d = 1'b0;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        w_rd_valid_d = w_rd_accept;
        w_rd_data_d  = r_rd_data_q;
        w_rd_oor_d   = r_rd_oor_q;
        w_rd_entry   = r_mem[w_rd_idx];
        // Write-first bypass when the same entry is written this cycle.
        if (w_wr_accept && (wr_addr == rd_addr)) begin
            w_rd_entry = wr_data;
        end
        if (w_rd_accept) begin
            if (w_rd_in_range) begin
                w_rd_data_d = OUT_W'($signed(w_rd_entry));
                w_rd_oor_d  = 1'b0;
            end else begin
                w_rd_data_d = OUT_W'($signed(OOR_VALUE));
                w_rd_oor_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q    <= ST_CLEAR;
            r_cnt_q      <= '0;
            r_ready_q    <= 1'b0;
            r_rd_valid_q <= 1'b0;
            r_rd_data_q  <= '0;
            r_rd_oor_q   <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_ready_q    <= w_ready_d;
            r_rd_valid_q <= w_rd_valid_d;
            r_rd_data_q  <= w_rd_data_d;
            r_rd_oor_q   <= w_rd_oor_d;
        end
    end

    // Table storage carries no reset; the clear sequencer initialises it.
    always_ff @(posedge clk) begin
        if (r_state_q == ST_CLEAR) begin
            r_mem[r_cnt_q] <= '0;
        end else if (w_wr_accept) begin
            r_mem[w_wr_idx] <= wr_data;
        end
    end

    assign ready    = r_ready_q;
    assign rd_valid = r_rd_valid_q;
    assign rd_data  = r_rd_data_q;
    assign rd_oor   = r_rd_oor_q;

endmodule

`default_nettype wire
